mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters: none; data path fixed at 64 bits, 8-byte bus lanes.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 inValid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 memRead  input  1  load instruction.
REQ-006 memWrite  input  1  store instruction.
REQ-007 memSize  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-008 memUnsigned  input  1  zero-extend the load result when 1, sign-extend when 0.
REQ-009 aluResult  input  64  effective address.
REQ-010 storeData  input  64  store source, right-aligned.
REQ-011 dreqValid  output  1  data-bus request valid.
REQ-012 dreqAddr  output  64  request address, 8-byte aligned (aluResult with bits [2:0] cleared).
REQ-013 dreqWrite  output  1  request is a store.
REQ-014 dreqStrobe  output  8  byte-lane write enables; 0 for loads.
REQ-015 dreqData  output  64  lane-aligned store data.
REQ-016 drespOk  input  1  bus completion, one-cycle pulse.
REQ-017 drespData  input  64  raw 64-bit load data, valid with drespOk.
REQ-018 memStall  output  1  upstream holds all EX/MEM inputs stable while 1.
REQ-019 outValid  output  1  MEM/WB slot valid; one-cycle pulse per retired instruction.
REQ-020 readData_M  output  64  extended load result, registered, feeds writeback select.
REQ-021 misalign  output  1  registered with outValid; access not naturally aligned.

Function
REQ-022 FSM states: IDLE and WAIT.
REQ-023 In IDLE, inValid with neither memRead nor memWrite: no bus request, outValid=1 next cycle, memStall=0.
REQ-024 In IDLE, inValid with a memory op and misaligned address (half: addr[0]; word: addr[1:0]; double: addr[2:0] nonzero): no bus request, outValid=1 and misalign=1 next cycle, memStall=0.
REQ-025 In IDLE, inValid with an aligned memory op: memStall=1 combinationally; next cycle state=WAIT with dreqValid=1.
REQ-026 In WAIT, dreqValid and all dreq* outputs hold stable until drespOk is sampled.
REQ-027 In WAIT, memStall = NOT drespOk; on drespOk the FSM returns to IDLE, outValid=1 next cycle, and the load result is captured into readData_M.
REQ-028 Minimum latency for a memory op: request cycle N+1, earliest outValid N+2 when drespOk arrives at N+1.
REQ-029 Both memRead and memWrite set: treated as a load, store ignored.
REQ-030 Store strobe: byte 0x01, half 0x03, word 0x0F, double 0xFF, each shifted left by addr[2:0].
REQ-031 Store data: storeData shifted left by 8*addr[2:0], truncated to 64 bits.
REQ-032 Load: drespData shifted right by 8*addr[2:0], low 8/16/32/64 bits kept, then sign- or zero-extended per memUnsigned.
REQ-033 drespOk in IDLE is ignored.
REQ-034 readData_M holds its last value on non-load completions.

Reset
REQ-035 Reset asserted: state=IDLE; dreqValid=0, outValid=0, misalign=0, readData_M=0, and all dreq* registers 0.
REQ-036 Reset asserted mid-WAIT abandons the request; a drespOk arriving after reset release is ignored.

Structure
REQ-037 Shared package holds the memSize encoding enum and the FSM state enum.
REQ-038 One sub-module, load_extend: combinational lane shift plus sign/zero extension.

Verification
REQ-039 lb at addr 0x1003, drespData=0x00000000_80000000 -> dreqAddr=0x1000, readData_M=0xFFFFFFFF_FFFFFF80.
REQ-040 sh at addr 0x2006, storeData=0xABCD -> dreqStrobe=0xC0, dreqData=0xABCD0000_00000000.
REQ-041 lw at addr 0x3002 -> no dreqValid; outValid=1 and misalign=1 next cycle.
REQ-042 ld at 0x4000 with drespOk delayed 5 cycles -> memStall=1 for 6 cycles, dreq* stable, single outValid pulse.
REQ-043 reset driven low during WAIT -> dreqValid=0 immediately; a later drespOk produces no outValid.
REQ-044 Back-to-back add then lhu at 0x5002 with drespData=0x0000_0000_F00D_0000 -> outValid pulses for both in order, readData_M=0x000000000000F00D.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage data-bus access block.
// Access-size encoding, FSM states and a few size helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SizeByte   = 2'd0,
    SizeHalf   = 2'd1,
    SizeWord   = 2'd2,
    SizeDouble = 2'd3
  } mem_size_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] offset);
    logic mis;
    unique case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = offset[0];
      SizeWord: mis = |offset[1:0];
      default:  mis = |offset;
    endcase
    return mis;
  endfunction

  // Unshifted byte-lane mask for an access of the given size.
  function automatic logic [7:0] size_strobe(input mem_size_e size);
    logic [7:0] strobe;
    unique case (size)
      SizeByte: strobe = 8'h01;
      SizeHalf: strobe = 8'h03;
      SizeWord: strobe = 8'h0F;
      default:  strobe = 8'hFF;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load-data alignment: moves the addressed lane down to bit 0 and
// sign- or zero-extends it to 64 bits.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  logic [63:0] shifted;
  logic        fill;

  always_comb begin
    shifted = raw >> {offset, 3'b000};
    fill    = 1'b0;
    result  = shifted;
    unique case (size)
      SizeByte: begin
        fill   = ~is_unsigned & shifted[7];
        result = {{56{fill}}, shifted[7:0]};
      end
      SizeHalf: begin
        fill   = ~is_unsigned & shifted[15];
        result = {{48{fill}}, shifted[15:0]};
      end
      SizeWord: begin
        fill   = ~is_unsigned & shifted[31];
        result = {{32{fill}}, shifted[31:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-bus access: issues one aligned request per load/store,
// stalls upstream until the bus completes, and retires into the MEM/WB slot.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [63:0] aluResult,
  input  logic [63:0] storeData,
  output logic        dreqValid,
  output logic [63:0] dreqAddr,
  output logic        dreqWrite,
  output logic [7:0]  dreqStrobe,
  output logic [63:0] dreqData,
  input  logic        drespOk,
  input  logic [63:0] drespData,
  output logic        memStall,
  output logic        outValid,
  output logic [63:0] readData_M,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic [63:0] dreq_addr_q, dreq_addr_d;
  logic        dreq_write_q, dreq_write_d;
  logic [7:0]  dreq_strobe_q, dreq_strobe_d;
  logic [63:0] dreq_data_q, dreq_data_d;
  logic        out_valid_q, out_valid_d;
  logic        misalign_q, misalign_d;
  logic [63:0] read_data_q, read_data_d;

  // Request attributes kept for extending the response.
  mem_size_e   size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [2:0]  offset_q, offset_d;
  logic        load_q, load_d;

  mem_size_e   size_in;
  logic [2:0]  offset_in;
  logic        is_mem;
  logic        is_store;
  logic [63:0] ext_result;

  assign size_in   = mem_size_e'(memSize);
  assign offset_in = aluResult[2:0];
  assign is_mem    = memRead | memWrite;
  assign is_store  = memWrite & ~memRead;

  load_extend u_load_extend (
    .raw         (drespData),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (ext_result)
  );

  always_comb begin
    state_d       = state_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_write_d  = dreq_write_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    out_valid_d   = 1'b0;
    misalign_d    = 1'b0;
    read_data_d   = read_data_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    offset_d      = offset_q;
    load_d        = load_q;
    memStall      = 1'b0;

    case (state_q)
      StIdle: begin
        if (inValid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
          end else if (is_misaligned(size_in, offset_in)) begin
            out_valid_d = 1'b1;
            misalign_d  = 1'b1;
          end else begin
            memStall      = 1'b1;
            state_d       = StWait;
            dreq_valid_d  = 1'b1;
            dreq_addr_d   = {aluResult[63:3], 3'b000};
            dreq_write_d  = is_store;
            dreq_strobe_d = is_store ? (size_strobe(size_in) << offset_in) : 8'h00;
            dreq_data_d   = is_store ? (storeData << {offset_in, 3'b000}) : 64'd0;
            size_d        = size_in;
            unsigned_d    = memUnsigned;
            offset_d      = offset_in;
            load_d        = memRead;
          end
        end
      end
      StWait: begin
        memStall = ~drespOk;
        if (drespOk) begin
          state_d       = StIdle;
          dreq_valid_d  = 1'b0;
          dreq_addr_d   = 64'd0;
          dreq_write_d  = 1'b0;
          dreq_strobe_d = 8'h00;
          dreq_data_d   = 64'd0;
          out_valid_d   = 1'b1;
          if (load_q) begin
            read_data_d = ext_result;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= 64'd0;
      dreq_write_q  <= 1'b0;
      dreq_strobe_q <= 8'h00;
      dreq_data_q   <= 64'd0;
      out_valid_q   <= 1'b0;
      misalign_q    <= 1'b0;
      read_data_q   <= 64'd0;
      size_q        <= SizeByte;
      unsigned_q    <= 1'b0;
      offset_q      <= 3'd0;
      load_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_write_q  <= dreq_write_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      out_valid_q   <= out_valid_d;
      misalign_q    <= misalign_d;
      read_data_q   <= read_data_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      offset_q      <= offset_d;
      load_q        <= load_d;
    end
  end

  assign dreqValid  = dreq_valid_q;
  assign dreqAddr   = dreq_addr_q;
  assign dreqWrite  = dreq_write_q;
  assign dreqStrobe = dreq_strobe_q;
  assign dreqData   = dreq_data_q;
  assign outValid   = out_valid_q;
  assign misalign   = misalign_q;
  assign readData_M = read_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written
// multi-cycle sequences, and random ops checked against a behavioural model.
module tb_mem_access;

  logic        clk, reset;
  logic        inValid, memRead, memWrite, memUnsigned;
  logic [1:0]  memSize;
  logic [63:0] aluResult, storeData;
  logic        dreqValid, dreqWrite;
  logic [63:0] dreqAddr, dreqData;
  logic [7:0]  dreqStrobe;
  logic        drespOk;
  logic [63:0] drespData;
  logic        memStall, outValid, misalign;
  logic [63:0] readData_M;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access dut (
    .clk         (clk),
    .reset       (reset),
    .inValid     (inValid),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memSize     (memSize),
    .memUnsigned (memUnsigned),
    .aluResult   (aluResult),
    .storeData   (storeData),
    .dreqValid   (dreqValid),
    .dreqAddr    (dreqAddr),
    .dreqWrite   (dreqWrite),
    .dreqStrobe  (dreqStrobe),
    .dreqData    (dreqData),
    .drespOk     (drespOk),
    .drespData   (drespData),
    .memStall    (memStall),
    .outValid    (outValid),
    .readData_M  (readData_M),
    .misalign    (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    int          delay;
  } op_t;

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        wr;
    logic [7:0]  strobe;
    logic [63:0] data;
    int          stall;
    logic        mis;
    logic [63:0] rd;
    logic        stable;
    int          pulses;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Expected outcome of one op, straight from the access rules.
  function automatic res_t model(input op_t op, input logic [63:0] prev_rd);
    res_t        r;
    int          nbytes, off, nbits;
    logic [15:0] m;
    logic [63:0] v, keep;
    r = '{default: 0};
    r.stable = 1'b1;
    r.pulses = 1;
    r.rd     = prev_rd;
    nbytes   = 1 << op.size;
    off      = int'(op.addr % 8);
    if (op.rd || op.wr) begin
      if ((op.addr % nbytes) != 0) begin
        r.mis = 1'b1;
      end else begin
        r.req   = 1'b1;
        r.addr  = op.addr - 64'(off);
        r.wr    = op.wr && !op.rd;
        r.stall = op.delay + 1;
        if (r.wr) begin
          m        = ((16'd1 << nbytes) - 16'd1) << off;
          r.strobe = m[7:0];
          r.data   = op.sdata << (8 * off);
        end else begin
          nbits = 8 * nbytes;
          v     = op.rdata >> (8 * off);
          if (nbits < 64) begin
            keep = (64'd1 << nbits) - 64'd1;
            v    = v & keep;
            if (!op.uns && v[nbits-1]) v = v | ~keep;
          end
          r.rd = v;
        end
      end
    end
    return r;
  endfunction

  // Drives one instruction, acts as the bus responder, and records what was observed.
  task automatic run_op(input op_t op, output res_t r);
    r = '{default: 0};
    r.stable = 1'b1;
    @(negedge clk);
    inValid     = 1'b1;
    memRead     = op.rd;
    memWrite    = op.wr;
    memSize     = op.size;
    memUnsigned = op.uns;
    aluResult   = op.addr;
    storeData   = op.sdata;
    #1;
    if (memStall) begin
      r.stall = 1;
      @(negedge clk);
      r.req    = dreqValid;
      r.addr   = dreqAddr;
      r.wr     = dreqWrite;
      r.strobe = dreqStrobe;
      r.data   = dreqData;
      for (int i = 0; i <= op.delay; i++) begin
        if (outValid) r.pulses++;
        if (dreqValid !== 1'b1 || dreqAddr !== r.addr || dreqWrite !== r.wr ||
            dreqStrobe !== r.strobe || dreqData !== r.data) r.stable = 1'b0;
        if (i == op.delay) begin
          drespOk   = 1'b1;
          drespData = op.rdata;
        end else begin
          drespData = {$urandom, $urandom};
        end
        #1;
        if (memStall) r.stall++;
        if (i < op.delay) @(negedge clk);
      end
    end
    @(negedge clk);
    inValid  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    drespOk  = 1'b0;
    if (r.stall == 0) r.req = dreqValid;
    if (outValid) r.pulses++;
    r.mis = misalign;
    r.rd  = readData_M;
    @(negedge clk);
    if (outValid) r.pulses++;
  endtask

  task automatic compare(input string name, input res_t got, input res_t exp);
    check({name, ".req"}, 64'(got.req), 64'(exp.req));
    if (exp.req) begin
      check({name, ".addr"}, got.addr, exp.addr);
      check({name, ".write"}, 64'(got.wr), 64'(exp.wr));
      check({name, ".strobe"}, 64'(got.strobe), 64'(exp.strobe));
      if (exp.wr) check({name, ".data"}, got.data, exp.data);
      check({name, ".stable"}, 64'(got.stable), 64'(exp.stable));
    end
    check({name, ".stall"}, 64'(got.stall), 64'(exp.stall));
    check({name, ".misalign"}, 64'(got.mis), 64'(exp.mis));
    check({name, ".readData"}, got.rd, exp.rd);
    check({name, ".pulses"}, 64'(got.pulses), 64'(exp.pulses));
  endtask

  vec_t        vecs[7];
  res_t        got, exp;
  op_t         op;
  logic [63:0] last_rd;

  initial begin
    reset = 1'b0; inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'd0;
    memUnsigned = 1'b0; aluResult = '0; storeData = '0; drespOk = 1'b0; drespData = '0;

    //            rd wr sz un addr         sdata                  rdata                  dly
    vecs[0].op = '{1, 0, 0, 0, 64'h1003, 64'h0,                64'h00000000_80000000, 0};
    vecs[0].exp = '{1, 64'h1000, 0, 8'h00, 64'h0, 1, 0, 64'hFFFFFFFF_FFFFFF80, 1, 1};
    vecs[1].op = '{0, 1, 1, 0, 64'h2006, 64'hABCD,             64'h0,                 2};
    vecs[1].exp = '{1, 64'h2000, 1, 8'hC0, 64'hABCD0000_00000000, 3, 0,
                    64'hFFFFFFFF_FFFFFF80, 1, 1};
    vecs[2].op = '{1, 0, 2, 0, 64'h3002, 64'h0,                64'h0,                 0};
    vecs[2].exp = '{0, 64'h0, 0, 8'h00, 64'h0, 0, 1, 64'hFFFFFFFF_FFFFFF80, 1, 1};
    vecs[3].op = '{1, 0, 3, 0, 64'h4000, 64'h0,                64'h11223344_55667788, 5};
    vecs[3].exp = '{1, 64'h4000, 0, 8'h00, 64'h0, 6, 0, 64'h11223344_55667788, 1, 1};
    vecs[4].op = '{0, 1, 3, 0, 64'h4008, 64'hDEADBEEF_CAFEF00D, 64'h0,                 1};
    vecs[4].exp = '{1, 64'h4008, 1, 8'hFF, 64'hDEADBEEF_CAFEF00D, 2, 0,
                    64'h11223344_55667788, 1, 1};
    vecs[5].op = '{1, 1, 2, 1, 64'h6004, 64'h1234,             64'h89ABCDEF_00000000, 0};
    vecs[5].exp = '{1, 64'h6000, 0, 8'h00, 64'h0, 1, 0, 64'h00000000_89ABCDEF, 1, 1};
    vecs[6].op = '{1, 0, 2, 0, 64'h6004, 64'h0,                64'h89ABCDEF_00000000, 0};
    vecs[6].exp = '{1, 64'h6000, 0, 8'h00, 64'h0, 1, 0, 64'hFFFFFFFF_89ABCDEF, 1, 1};

    repeat (2) @(negedge clk);
    check("reset.dreqValid", 64'(dreqValid), 64'd0);
    check("reset.dreqAddr", dreqAddr, 64'd0);
    check("reset.dreqWrite", 64'(dreqWrite), 64'd0);
    check("reset.dreqStrobe", 64'(dreqStrobe), 64'd0);
    check("reset.dreqData", dreqData, 64'd0);
    check("reset.outValid", 64'(outValid), 64'd0);
    check("reset.misalign", 64'(misalign), 64'd0);
    check("reset.readData", readData_M, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, got);
      compare($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    last_rd = 64'hFFFFFFFF_89ABCDEF;

    // A stray response while idle must not retire anything.
    @(negedge clk);
    drespOk = 1'b1; drespData = 64'h5555_5555_5555_5555;
    @(negedge clk);
    drespOk = 1'b0;
    check("idle_resp.outValid", 64'(outValid), 64'd0);
    check("idle_resp.readData", readData_M, last_rd);

    // Non-memory op immediately followed by an unsigned halfword load.
    @(negedge clk);
    inValid = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    #1 check("b2b.add_stall", 64'(memStall), 64'd0);
    @(negedge clk);
    check("b2b.add_out", 64'(outValid), 64'd1);
    check("b2b.add_mis", 64'(misalign), 64'd0);
    memRead = 1'b1; memSize = 2'd1; memUnsigned = 1'b1; aluResult = 64'h5002;
    #1 check("b2b.lhu_stall", 64'(memStall), 64'd1);
    @(negedge clk);
    check("b2b.lhu_early_out", 64'(outValid), 64'd0);
    check("b2b.lhu_req", 64'(dreqValid), 64'd1);
    check("b2b.lhu_addr", dreqAddr, 64'h5000);
    drespOk = 1'b1; drespData = 64'h00000000_F00D0000;
    @(negedge clk);
    drespOk = 1'b0; inValid = 1'b0; memRead = 1'b0;
    check("b2b.lhu_out", 64'(outValid), 64'd1);
    check("b2b.lhu_data", readData_M, 64'h00000000_0000F00D);
    last_rd = 64'h00000000_0000F00D;

    for (int i = 0; i < 40; i++) begin
      op.rd    = 1'($urandom_range(0, 1));
      op.wr    = 1'($urandom_range(0, 1));
      op.size  = 2'($urandom_range(0, 3));
      op.uns   = 1'($urandom_range(0, 1));
      op.addr  = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) op.addr = op.addr & ~((64'd1 << op.size) - 64'd1);
      op.sdata = {$urandom, $urandom};
      op.rdata = {$urandom, $urandom};
      op.delay = $urandom_range(0, 3);
      exp = model(op, last_rd);
      run_op(op, got);
      compare($sformatf("rand%0d", i), got, exp);
      last_rd = exp.rd;
    end

    // Reset in the middle of a wait drops the request; a late response is ignored.
    @(negedge clk);
    inValid = 1'b1; memRead = 1'b1; memSize = 2'd3; aluResult = 64'h7000;
    @(negedge clk);
    check("rst_wait.req", 64'(dreqValid), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_wait.req_drop", 64'(dreqValid), 64'd0);
    check("rst_wait.readData", readData_M, 64'd0);
    @(negedge clk);
    reset = 1'b1; inValid = 1'b0; memRead = 1'b0;
    @(negedge clk);
    drespOk = 1'b1; drespData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    drespOk = 1'b0;
    check("rst_wait.late_out", 64'(outValid), 64'd0);
    @(negedge clk);
    check("rst_wait.late_out2", 64'(outValid), 64'd0);
    check("rst_wait.late_data", readData_M, 64'd0);
    check("rst_wait.no_req", 64'(dreqValid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
